maxpool_stream: RTL and testbench

//  Streaming, parametrised max-pooling unit for the downsample path. Accepts LANES channels per beat,

---
 rtl/pool_pkg.sv | 18 +
 rtl/pool_lane_cmp.sv | 68 ++++++
 rtl/maxpool_stream.sv | 128 ++++++++++++
 tb/tb_maxpool_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the max-pooling stream unit.
// Holds the default geometry, the derived beat-counter width, the FSM state type
// and a lane slice type. Optional feature macro used by the pool RTL: MAXPOOL_ARGMAX_EN.
package pool_pkg;

  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned LANES_DEF   = 4;
  localparam int unsigned MAX_WIN_DEF = 4;
  localparam int unsigned WCW_DEF     = $clog2(MAX_WIN_DEF + 1);

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } pool_state_e;

  typedef logic [DW_DEF-1:0] lane_t;

endpackage

// File: rtl/pool_lane_cmp.sv
// One lane of the max-pool reducer.
// Holds the running maximum (and, with MAXPOOL_ARGMAX_EN, the beat index of that maximum).
// max_data/max_idx are the combinational merge of the stored state with the current beat, so
// the top can register them as the result on the final beat of a window.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   beat_en     current beat is accepted
//   first       current beat opens a window (load instead of compare)
//   clear       abort of a partial window, clears the accumulator
//   beat_idx    index of the current beat inside its window
//   in_data     lane value of the current beat
//   max_data    maximum including the current beat
//   max_idx     beat index of max_data (0 when MAXPOOL_ARGMAX_EN is not defined)
module pool_lane_cmp #(
  parameter int unsigned DW  = 32,
  parameter int unsigned WCW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           beat_en,
  input  logic           first,
  input  logic           clear,
  input  logic [WCW-1:0] beat_idx,
  input  logic [DW-1:0]  in_data,
  output logic [DW-1:0]  max_data,
  output logic [WCW-1:0] max_idx
);

  logic [DW-1:0] acc_q;
  logic          take;

  // Strict compare: ties keep the earlier beat.
  assign take     = first || (in_data > acc_q);
  assign max_data = take ? in_data : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (beat_en) begin
      acc_q <= max_data;
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [WCW-1:0] idx_q;

  // beat_idx is 0 on the first beat, so no separate first-beat case is needed.
  assign max_idx = take ? beat_idx : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (beat_en) begin
      idx_q <= max_idx;
    end
  end
`else
  logic unused_beat_idx;

  assign unused_beat_idx = ^beat_idx;
  assign max_idx         = '0;
`endif

endmodule

// File: rtl/maxpool_stream.sv
// Streaming max-pool unit: reduces win_len consecutive beats per lane to their maximum and
// emits one result beat per window, with a one-cycle latency from the final beat.
// Optional feature: define MAXPOOL_ARGMAX_EN to drive out_idx with the winning beat index.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   win_len               window length 1..MAX_WIN (larger clamps), 0 = inactive
//   flush                 synchronous abort of a partial window
//   in_valid/in_ready     input handshake, in_data lane i at [i*DW +: DW]
//   out_valid/out_ready   output handshake
//   out_data              per-lane maximum
//   out_idx               per-lane argmax beat index, lane i at [i*WCW +: WCW]
module maxpool_stream import pool_pkg::*; #(
  parameter int unsigned  DW      = DW_DEF,
  parameter int unsigned  LANES   = LANES_DEF,
  parameter int unsigned  MAX_WIN = MAX_WIN_DEF,
  localparam int unsigned WCW     = $clog2(MAX_WIN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WCW-1:0]       win_len,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*DW-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*DW-1:0]  out_data,
  output logic [LANES*WCW-1:0] out_idx
);

  localparam logic [WCW-1:0] MaxWin = WCW'(MAX_WIN);
  localparam logic [WCW-1:0] One    = WCW'(1);

  pool_state_e          state_q;
  logic [WCW-1:0]       cnt_q;
  logic [WCW-1:0]       win_q;
  logic                 run_q;
  logic                 out_valid_q;
  logic [LANES*DW-1:0]  out_data_q;

  logic [WCW-1:0]       win_eff;
  logic                 first;
  logic                 accept;
  logic                 final_beat;
  logic [LANES*DW-1:0]  lane_max;
  logic [LANES*WCW-1:0] lane_idx;

  assign win_eff = (win_len > MaxWin) ? MaxWin : win_len;
  assign first   = (state_q == StIdle);

  // run_q keeps in_ready low while in reset and for the first edge after release.
  assign in_ready = run_q && (!first || (win_len != '0)) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign final_beat = first ? (win_eff == One) : (cnt_q == (win_q - One));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pool_lane_cmp #(
      .DW (DW),
      .WCW(WCW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .beat_en (accept),
      .first   (first),
      .clear   (flush),
      .beat_idx(cnt_q),
      .in_data (in_data[i*DW +: DW]),
      .max_data(lane_max[i*DW +: DW]),
      .max_idx (lane_idx[i*WCW +: WCW])
    );
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [LANES*WCW-1:0] out_idx_q;

  assign out_idx = out_idx_q;
`else
  logic unused_lane_idx;

  assign unused_lane_idx = ^lane_idx;
  assign out_idx         = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      win_q       <= '0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef MAXPOOL_ARGMAX_EN
      out_idx_q   <= '0;
`endif
    end else begin
      run_q <= 1'b1;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A pending result survives flush; only the partial window is dropped.
      if (flush) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else if (accept) begin
        if (final_beat) begin
          state_q     <= StIdle;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= lane_max;
`ifdef MAXPOOL_ARGMAX_EN
          out_idx_q   <= lane_idx;
`endif
        end else if (first) begin
          state_q <= StAccum;
          win_q   <= win_eff;
          cnt_q   <= One;
        end else begin
          cnt_q <= cnt_q + One;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: a queue-based window model checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_maxpool_stream;

  localparam int DW      = 32;
  localparam int LANES   = 4;
  localparam int MAX_WIN = 4;
  localparam int WCW     = 3;
  localparam int BW      = LANES * DW;
  localparam int IW      = LANES * WCW;

  logic          clk;
  logic          rst_n;
  logic [WCW-1:0] win_len;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [IW-1:0] out_idx;

  maxpool_stream #(
    .DW     (DW),
    .LANES  (LANES),
    .MAX_WIN(MAX_WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .win_len  (win_len),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int dut_hs = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [DW-1:0] va, vb, vc, vd;
    va = DW'(a); vb = DW'(b); vc = DW'(c); vd = DW'(d);
    return {vd, vc, vb, va};
  endfunction

  function automatic logic [IW-1:0] pki(input int a, input int b, input int c, input int d);
    logic [WCW-1:0] va, vb, vc, vd;
    va = WCW'(a); vb = WCW'(b); vc = WCW'(c); vd = WCW'(d);
    return {vd, vc, vb, va};
  endfunction

  // Expected argmax as seen on the port, depending on the build.
  function automatic logic [IW-1:0] exp_idx(input logic [IW-1:0] idx);
`ifdef MAXPOOL_ARGMAX_EN
    return idx;
`else
    return (idx & '0);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  bit            m_open, m_started, m_valid;
  int            m_wq;
  logic [BW-1:0] m_beats[$];
  logic [BW-1:0] m_data;
  logic [IW-1:0] m_idx;

  function automatic bit m_rdy();
    return m_started && (m_open || (win_len != 0)) && (!m_valid || out_ready) && !flush;
  endfunction

  task automatic m_reset();
    m_open = 0; m_started = 0; m_valid = 0; m_wq = 0;
    m_beats.delete();
    m_data = '0; m_idx = '0;
  endtask

  // Max over the whole window per lane; first occurrence wins ties.
  task automatic m_produce();
    logic [BW-1:0] b;
    logic [DW-1:0] best, v;
    int bi;
    for (int l = 0; l < LANES; l++) begin
      b = m_beats[0];
      best = b[l*DW +: DW];
      bi = 0;
      for (int k = 1; k < m_beats.size(); k++) begin
        b = m_beats[k];
        v = b[l*DW +: DW];
        if (v > best) begin
          best = v;
          bi = k;
        end
      end
      m_data[l*DW +: DW] = best;
      m_idx[l*WCW +: WCW] = WCW'(bi);
    end
  endtask

  task automatic m_step();
    bit r;
    r = m_rdy();
    if (m_valid && out_ready) m_valid = 0;
    if (flush) begin
      m_open = 0;
      m_beats.delete();
    end else if (r && in_valid) begin
      if (!m_open) begin
        m_wq = (int'(win_len) > MAX_WIN) ? MAX_WIN : int'(win_len);
        m_beats.delete();
      end
      m_beats.push_back(in_data);
      if (m_beats.size() >= m_wq) begin
        m_produce();
        m_valid = 1;
        m_open = 0;
      end else begin
        m_open = 1;
      end
    end
    m_started = 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", BW'(in_ready), BW'(m_rdy()));
      chk("out_valid", BW'(out_valid), BW'(m_valid));
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_idx", BW'(out_idx), BW'(exp_idx(m_idx)));
      end
      if (out_valid && out_ready) dut_hs++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [BW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: in_ready never rose for data %0h", d);
    in_valid = 1'b0;
  endtask

  int hs0;
  int nvalid;

  initial begin
    rst_n = 1'b0; win_len = 3; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("reset_in_ready", BW'(in_ready), '0);
    chk("reset_out_valid", BW'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_idx", BW'(out_idx), '0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // 1: window of 3, lane0 5,9,2 -> 9 at beat index 1
    out_ready = 1'b0;
    send(pk(5, 1, 3, 0));
    send(pk(9, 1, 2, 0));
    chk("t1_not_early", BW'(out_valid), '0);
    send(pk(2, 8, 1, 0));
    chk("t1_valid", BW'(out_valid), BW'(1));
    chk("t1_data", out_data, pk(9, 8, 3, 0));
    chk("t1_idx", BW'(out_idx), BW'(exp_idx(pki(1, 2, 0, 0))));
    out_ready = 1'b1;
    tick(1);

    // 2: ties keep the first beat, then inactive mode
    win_len = 2;
    send(pk(7, 7, 7, 7));
    send(pk(7, 7, 7, 7));
    chk("t2_data", out_data, pk(7, 7, 7, 7));
    chk("t2_idx", BW'(out_idx), BW'(exp_idx(pki(0, 0, 0, 0))));
    tick(1);
    win_len = 0;
    in_valid = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t2_inactive_ready", BW'(in_ready), '0);
      if (out_valid) nvalid++;
    end
    chk("t2_no_output", BW'(nvalid), '0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // 3: win_len=1 at full rate
    win_len = 1;
    hs0 = dut_hs;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = pk(i + 1, 20 - i, i * 3, 100);
      @(negedge clk);
      chk("t3_ready_held", BW'(in_ready), BW'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tick(2);
    chk("t3_result_count", BW'(dut_hs - hs0), BW'(8));

    // 4: output stall blocks input and holds data
    out_ready = 1'b0;
    win_len = 2;
    send(pk(10, 20, 30, 40));
    send(pk(15, 5, 30, 50));
    in_valid = 1'b1;
    in_data = pk(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_ready", BW'(in_ready), '0);
      chk("t4_stall_data", out_data, pk(15, 20, 30, 50));
      chk("t4_stall_idx", BW'(out_idx), BW'(exp_idx(pki(1, 0, 0, 1))));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(pk(1, 2, 3, 4));
    send(pk(4, 3, 3, 1));
    chk("t4_after_data", out_data, pk(4, 3, 3, 4));
    chk("t4_after_idx", BW'(out_idx), BW'(exp_idx(pki(1, 1, 0, 0))));

    // 5: flush after 2 of 4 beats
    win_len = 4;
    send(pk(100, 100, 100, 100));
    send(pk(200, 200, 200, 200));
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("t5_flush_no_output", BW'(nvalid), '0);
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) send(pk(i, i, i, i));
    chk("t5_data", out_data, pk(4, 4, 4, 4));
    chk("t5_idx", BW'(out_idx), BW'(exp_idx(pki(3, 3, 3, 3))));
    tick(1);

    // 6: reset mid-window, then reset with a pending output
    win_len = 3;
    send(pk(50, 50, 50, 50));
    send(pk(60, 60, 60, 60));
    rst_n = 1'b0;
    #1;
    chk("t6a_out_valid", BW'(out_valid), '0);
    chk("t6a_out_data", out_data, '0);
    chk("t6a_in_ready", BW'(in_ready), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    out_ready = 1'b0;
    win_len = 1;
    send(pk(77, 66, 55, 44));
    chk("t6b_pending", BW'(out_valid), BW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6b_out_valid", BW'(out_valid), '0);
    chk("t6b_out_data", out_data, '0);
    chk("t6b_out_idx", BW'(out_idx), '0);
    chk("t6b_in_ready", BW'(in_ready), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    win_len = 3;
    send(pk(10, 10, 10, 10));
    send(pk(30, 5, 30, 11));
    send(pk(20, 40, 30, 9));
    chk("t6_fresh_data", out_data, pk(30, 40, 30, 11));
    chk("t6_fresh_idx", BW'(out_idx), BW'(exp_idx(pki(1, 2, 1, 1))));
    tick(2);

    // Randomized phase: model comparison runs every cycle.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) win_len = WCW'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 1) == 0) in_data[l*DW +: DW] = DW'($urandom_range(0, 7));
        else in_data[l*DW +: DW] = DW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick(1);
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
